// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with sync decode, pixel coordinates and delayed outputs
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10,
    parameter int DELAY    = 2,
    parameter int FRAME_W  = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               enable,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             br;
        logic [CNT_W-1:0] px;
        logic [CNT_W-1:0] py;
        logic             ls;
        logic             fs;
    } bundle_t;

    // Idle level of every output: syncs inactive, no active video, origin coordinates
    localparam bundle_t RST_B = '{hs: !HS_POL, vs: !VS_POL, br: 1'b0,
                                  px: '0, py: '0, ls: 1'b0, fs: 1'b0};

    logic [CNT_W-1:0]   hc;
    logic [CNT_W-1:0]   vc;
    logic [31:0]        hc32;
    logic [31:0]        vc32;
    logic               h_wrap;
    logic               v_wrap;
    bundle_t            dec;
    bundle_t            q;

    assign h_wrap = (hc == H_LAST);
    assign v_wrap = (vc == V_LAST);
    assign hc32   = 32'(hc);
    assign vc32   = 32'(vc);

    // Pixel/line counters and completed-frame counter, advanced by the pixel strobe
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
        end else if (enable) begin
            if (h_wrap) begin
                hc <= '0;
                if (v_wrap) begin
                    vc          <= '0;
                    frame_count <= frame_count + 1'b1;
                end else begin
                    vc <= vc + 1'b1;
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // Decode the current counter position into the output bundle
    always_comb begin
        dec    = RST_B;
        dec.hs = ((hc32 >= 32'(HS_START)) && (hc32 < 32'(HS_END))) ? HS_POL : !HS_POL;
        dec.vs = ((vc32 >= 32'(VS_START)) && (vc32 < 32'(VS_END))) ? VS_POL : !VS_POL;
        dec.br = (hc32 < 32'(H_ACTIVE)) && (vc32 < 32'(V_ACTIVE));
        dec.px = hc;
        dec.py = vc;
        dec.ls = (hc == '0);
        dec.fs = (hc == '0) && (vc == '0);
    end

    generate
        if (DELAY == 0) begin : g_nodly
            assign q = dec;
        end else begin : g_dly
            bundle_t stage [DELAY];

            // Shift register aligning the decode with the downstream pixel pipeline
            always_ff @(posedge clock or negedge clear) begin
                if (!clear) begin
                    for (int i = 0; i < DELAY; i++) begin
                        stage[i] <= RST_B;
                    end
                end else if (enable) begin
                    stage[0] <= dec;
                    for (int i = 1; i < DELAY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[DELAY-1];
        end
    endgenerate

    assign hSync       = q.hs;
    assign vSync       = q.vs;
    assign bright      = q.br;
    assign x           = q.px;
    assign y           = q.py;
    assign line_start  = q.ls;
    assign frame_start = q.fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen on a small raster
module tb_vga_timing_gen;

    logic clock = 1'b0;
    logic clear = 1'b0;
    logic enable = 1'b0;

    always #5 clock = ~clock;

    logic       hs0, vs0, br0, ls0, fs0;
    logic [9:0] x0, y0;
    logic [7:0] fc0;

    logic       hs3, vs3, br3, ls3, fs3;
    logic [9:0] x3, y3;
    logic [7:0] fc3;

    logic       hsp, vsp, brp, lsp, fsp;
    logic [9:0] xp, yp;
    logic [1:0] fcp;

    vga_timing_gen #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .DELAY(0)) dut0 (
        .clock(clock), .clear(clear), .enable(enable),
        .hSync(hs0), .vSync(vs0), .bright(br0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0), .frame_count(fc0));

    vga_timing_gen #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .DELAY(3)) dut3 (
        .clock(clock), .clear(clear), .enable(enable),
        .hSync(hs3), .vSync(vs3), .bright(br3), .x(x3), .y(y3),
        .line_start(ls3), .frame_start(fs3), .frame_count(fc3));

    vga_timing_gen #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .DELAY(1), .FRAME_W(2)) dutp (
        .clock(clock), .clear(clear), .enable(enable),
        .hSync(hsp), .vSync(vsp), .bright(brp), .x(xp), .y(yp),
        .line_start(lsp), .frame_start(fsp), .frame_count(fcp));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Expected bundle for a raster of 8 pixels x 6 lines; k < 0 selects the idle bundle
    task automatic chk_bundle(input string tag, input int k, input logic hs, input logic vs,
                              input logic br, input logic [9:0] xx, input logic [9:0] yy,
                              input logic ls, input logic fs);
        int h, v;
        logic ehs, evs, ebr, els, efs;
        if (k < 0) begin
            h = 0; v = 0; ehs = 1'b1; evs = 1'b1; ebr = 1'b0; els = 1'b0; efs = 1'b0;
        end else begin
            h   = k % 8;
            v   = (k / 8) % 6;
            ehs = !(h == 5 || h == 6);
            evs = (v != 4);
            ebr = (h < 4) && (v < 3);
            els = (h == 0);
            efs = (h == 0) && (v == 0);
        end
        chk({tag, ".hSync"}, k, 32'(hs), 32'(ehs));
        chk({tag, ".vSync"}, k, 32'(vs), 32'(evs));
        chk({tag, ".bright"}, k, 32'(br), 32'(ebr));
        chk({tag, ".x"}, k, 32'(xx), 32'(h));
        chk({tag, ".y"}, k, 32'(yy), 32'(v));
        chk({tag, ".line_start"}, k, 32'(ls), 32'(els));
        chk({tag, ".frame_start"}, k, 32'(fs), 32'(efs));
    endtask

    // Active-high syncs, one stage of delay
    task automatic chk_pol(input int k);
        logic ehs, evs;
        if (k < 1) begin
            ehs = 1'b0; evs = 1'b0;
        end else begin
            ehs = ((k - 1) % 8 == 5) || ((k - 1) % 8 == 6);
            evs = (((k - 1) / 8) % 6 == 4);
        end
        chk("pol.hSync", k, 32'(hsp), 32'(ehs));
        chk("pol.vSync", k, 32'(vsp), 32'(evs));
    endtask

    task automatic chk_all(input int k);
        chk_bundle("d0", k, hs0, vs0, br0, x0, y0, ls0, fs0);
        chk_bundle("d3", (k >= 3) ? k - 3 : -1, hs3, vs3, br3, x3, y3, ls3, fs3);
        chk_pol(k);
    endtask

    initial begin
        int n_bright, n_hslow, n_vslow, n_fs, n_gate_hslow, k;

        // Held in reset
        clear  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clock);
        chk_all(0);
        chk("rst.fc0", 0, 32'(fc0), 32'd0);
        chk("rst.fcp", 0, 32'(fcp), 32'd0);

        // Release: DELAY 0 shows origin decode immediately
        clear = 1'b1;
        #1;
        chk_all(0);

        // Five full frames at full rate
        n_bright = 0; n_hslow = 0; n_vslow = 0; n_fs = 0;
        for (int n = 1; n <= 240; n++) begin
            @(negedge clock);
            chk_all(n);
            if (n <= 48) begin
                if (br0) n_bright++;
                if (!hs0) n_hslow++;
                if (!vs0) n_vslow++;
            end
            if (fs0) n_fs++;
            if (n == 144) begin
                chk("fc0@144", n, 32'(fc0), 32'd3);
                chk("fc3@144", n, 32'(fc3), 32'd3);
                chk("fcp@144", n, 32'(fcp), 32'd3);
            end
        end
        chk("bright_per_frame", 48, 32'(n_bright), 32'd12);
        chk("hs_low_per_frame", 48, 32'(n_hslow), 32'd12);
        chk("vs_low_per_frame", 48, 32'(n_vslow), 32'd8);
        chk("fs_per_5_frames", 240, 32'(n_fs), 32'd5);
        chk("fc0@240", 240, 32'(fc0), 32'd5);
        chk("fcp@240", 240, 32'(fcp), 32'd1);

        // Enable every 4th clock: outputs follow strobe count and hold between strobes
        n_gate_hslow = 0;
        for (int j = 0; j < 64; j++) begin
            enable = (j % 4 == 0);
            @(negedge clock);
            k = 240 + j / 4 + 1;
            chk_all(k);
            if (!hs0) n_gate_hslow++;
        end
        chk("gate_hs_low_clocks", 64, 32'(n_gate_hslow), 32'd16);
        chk("gate_fc0_hold", 64, 32'(fc0), 32'd5);
        chk("gate_fcp_hold", 64, 32'(fcp), 32'd1);

        // Move mid-line, then clear asynchronously between edges
        enable = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clock);
            chk_all(256 + n);
        end
        chk("pre_clear.x0", 259, 32'(x0), 32'd3);
        chk("pre_clear.y0", 259, 32'(y0), 32'd2);
        #2;
        clear = 1'b0;
        #1;
        chk_all(0);
        chk("async.fc0", 0, 32'(fc0), 32'd0);
        chk("async.fcp", 0, 32'(fcp), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clock);
            chk_all(n);
        end
        chk("restart.fc0", 6, 32'(fc0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
